// File: rtl/aes_sbox_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_seq_pkg
//  Purpose  : Shared definitions for the masked S-box word sequencer:
//             sequencer state encoding, byte count, default S-box latency and
//             the share/bit index helper used for in_data, sb_i and out_data.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_sbox_seq_pkg;

   localparam int NB_BYTES         = 4;
   localparam int IDX_W            = $clog2(NB_BYTES);
   localparam int SBOX_LAT_DEFAULT = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   // Bit offset of share 0 of bit j of byte b. Shares of one bit are adjacent,
   // so a whole byte of shares is the contiguous slice starting at
   // share_idx(b, 0, nshares) and 8*nshares wide.
   function automatic int share_idx(input int b, input int j, input int nshares);
      return (8 * b + j) * nshares;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_lat_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : sbox_lat_tracker
//  Purpose  : Follows issued bytes through the fixed-latency S-box pipeline.
//             vsr[0] is aligned with the registered sb_i; a '1' reaching
//             vsr[SBOX_LAT] means sb_o carries a valid substituted byte.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             issue         - a valid byte is being loaded into sb_i this cycle
//             cap           - sb_o holds a valid byte this cycle
//             cap_idx       - byte position of that byte inside the word
//             inflight      - any valid byte in the S-box pipeline
//  Revision : 1.0 - initial release
// ============================================================================
module sbox_lat_tracker
   import aes_sbox_seq_pkg::*;
#(
   parameter int SBOX_LAT = SBOX_LAT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   output logic             cap,
   output logic [IDX_W-1:0] cap_idx,
   output logic             inflight
);

   logic [SBOX_LAT:0] vsr_q, vsr_d;
   logic [IDX_W-1:0]  c_q, c_d;

   always_comb begin
      vsr_d = {vsr_q[SBOX_LAT-1:0], issue};
      c_d   = c_q;
      // Bytes come back in issue order, so a plain counter names them.
      if (vsr_q[SBOX_LAT]) begin
         c_d = c_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsr_q <= '0;
         c_q   <= '0;
      end else begin
         vsr_q <= vsr_d;
         c_q   <= c_d;
      end
   end

   assign cap      = vsr_q[SBOX_LAT];
   assign cap_idx  = c_q;
   assign inflight = |vsr_q;

endmodule
`default_nettype wire

// File: rtl/aes_sbox_word_seq.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sbox_word_seq
//  Purpose  : Drive-side sequencer for a free-running masked bitsliced AES
//             S-box. Takes one D-share 32-bit word, feeds its four bytes into
//             the S-box one per cycle (gated by randomness availability),
//             collects the four substituted bytes after SBOX_LAT cycles and
//             presents them as a shared 32-bit word. Shares are only routed,
//             never recombined.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             in_valid/in_ready/in_data    - input word handshake
//             rnd_valid/rnd_ready          - S-box randomness gating
//             sb_i / sb_o                  - to / from the external S-box
//             out_valid/out_ready/out_data - output word handshake
//             busy                         - sequencer not idle
//             rnd_err                      - sticky randomness starvation
//  Revision : 1.0 - initial release
// ============================================================================
module aes_sbox_word_seq
   import aes_sbox_seq_pkg::*;
#(
   parameter int D        = 2,
   parameter int SBOX_LAT = SBOX_LAT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [32*D-1:0] in_data,
   input  logic            rnd_valid,
   output logic            rnd_ready,
   output logic [8*D-1:0]  sb_i,
   input  logic [8*D-1:0]  sb_o,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [32*D-1:0] out_data,
   output logic            busy,
   output logic            rnd_err
);

   localparam int BYTE_W = 8 * D;

   state_e            state_q, state_d;
   logic [32*D-1:0]   in_q_q, in_q_d;
   logic [32*D-1:0]   out_q_q, out_q_d;
   logic [BYTE_W-1:0] sb_i_q, sb_i_d;
   // One extra bit so "all four issued" is distinguishable from "none issued".
   logic [IDX_W:0]    k_q, k_d;
   logic              rnd_err_q, rnd_err_d;

   logic              issue;
   logic              cap;
   logic [IDX_W-1:0]  cap_idx;
   logic              inflight;

   sbox_lat_tracker #(
      .SBOX_LAT (SBOX_LAT)
   ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .issue    (issue),
      .cap      (cap),
      .cap_idx  (cap_idx),
      .inflight (inflight)
   );

   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign rnd_ready = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) && !rst;
   assign out_valid = (state_q == ST_OUT);
   assign busy      = (state_q != ST_IDLE);
   assign out_data  = out_q_q;
   assign sb_i      = sb_i_q;
   assign rnd_err   = rnd_err_q;

   always_comb begin
      state_d   = state_q;
      in_q_d    = in_q_q;
      out_q_d   = out_q_q;
      k_d       = k_q;
      sb_i_d    = '0;     // S-box sees zeros whenever no byte is issued
      issue     = 1'b0;
      rnd_err_d = rnd_err_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               in_q_d  = in_data;
               k_d     = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A byte may only enter the S-box together with fresh randomness.
            if (rnd_valid) begin
               sb_i_d  = in_q_q[share_idx(int'(k_q[IDX_W-1:0]), 0, D) +: BYTE_W];
               issue   = 1'b1;
               k_d     = k_q + (IDX_W+1)'(1);
               if (k_q == (IDX_W+1)'(NB_BYTES - 1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Waiting for the remaining bytes to leave the S-box.
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Captures can already start while issue is still stalled, so they are
      // handled independently of the state decode above.
      if (cap) begin
         out_q_d[share_idx(int'(cap_idx), 0, D) +: BYTE_W] = sb_o;
         if (cap_idx == IDX_W'(NB_BYTES - 1)) begin
            state_d = ST_OUT;
         end
      end

      if (rnd_ready && !rnd_valid && (inflight || (k_q != '0))) begin
         rnd_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         in_q_q    <= '0;
         out_q_q   <= '0;
         sb_i_q    <= '0;
         k_q       <= '0;
         rnd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_q_q    <= in_q_d;
         out_q_q   <= out_q_d;
         sb_i_q    <= sb_i_d;
         k_q       <= k_d;
         rnd_err_q <= rnd_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_sbox_word_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_sbox_word_seq
//  Purpose  : Self-checking bench for aes_sbox_word_seq. Models the external
//             masked S-box as a SBOX_LAT-deep pipeline that unmasks, looks up
//             a GF(2^8)-derived AES S-box table and re-masks with fresh shares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sbox_word_seq;

   localparam int D           = 2;
   localparam int LAT         = 6;
   localparam int WORD_LAT    = 6 + LAT;
   localparam int WORD_PERIOD = 7 + LAT;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [32*D-1:0] in_data = '0;
   logic            rnd_valid = 1'b1;
   logic            rnd_ready;
   logic [8*D-1:0]  sb_i;
   logic [8*D-1:0]  sb_o;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [32*D-1:0] out_data;
   logic            busy;
   logic            rnd_err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0]     sbox_tab [256];
   logic [8*D-1:0] pipe [LAT];

   aes_sbox_word_seq #(
      .D        (D),
      .SBOX_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rnd_valid (rnd_valid),
      .rnd_ready (rnd_ready),
      .sb_i      (sb_i),
      .sb_o      (sb_o),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .rnd_err   (rnd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference helpers ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] unmask8(input logic [8*D-1:0] s);
      logic [7:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) r[j] = ^s[j*D +: D];
      return r;
   endfunction

   function automatic logic [31:0] unmask32(input logic [32*D-1:0] s);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 32; j++) r[j] = ^s[j*D +: D];
      return r;
   endfunction

   function automatic logic [8*D-1:0] mask8(input logic [7:0] v);
      logic [8*D-1:0] s;
      logic           acc, rb;
      s = '0;
      for (int j = 0; j < 8; j++) begin
         acc = 1'b0;
         for (int k = 0; k < D - 1; k++) begin
            rb = 1'($urandom_range(1));
            s[j*D + k] = rb;
            acc = acc ^ rb;
         end
         s[j*D + D - 1] = v[j] ^ acc;
      end
      return s;
   endfunction

   function automatic logic [32*D-1:0] mask32(input logic [31:0] v);
      logic [32*D-1:0] s;
      logic            acc, rb;
      s = '0;
      for (int j = 0; j < 32; j++) begin
         acc = 1'b0;
         for (int k = 0; k < D - 1; k++) begin
            rb = 1'($urandom_range(1));
            s[j*D + k] = rb;
            acc = acc ^ rb;
         end
         s[j*D + D - 1] = v[j] ^ acc;
      end
      return s;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   // ---------------- external masked S-box model ----------------
   always @(posedge clk) begin
      pipe[0] <= mask8(sbox_tab[unmask8(sb_i)]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sb_o = pipe[LAT-1];

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called at a negedge; returns at the negedge one cycle after the out handshake.
   task automatic run_word(input logic [31:0] w, input int stall_n, input int bp_n,
                           output int lat, output logic [31:0] got, output int hs_cyc);
      logic [32*D-1:0] held;
      int              n;
      bit              ok;
      lat      = -1;
      got      = '0;
      in_data  = mask32(w);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      hs_cyc = cyc;
      if (!in_ready) begin
         check("in_ready_timeout", 128'(in_ready), 128'(1));
         in_valid = 1'b0;
         return;
      end
      out_ready = (bp_n == 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = mask32($urandom);
      n = 1;
      while (n < 40) begin
         rnd_valid = !(n >= 2 && n < 2 + stall_n);
         if (out_valid) break;
         @(negedge clk);
         n++;
      end
      rnd_valid = 1'b1;
      if (!out_valid) begin
         check("out_valid_timeout", 128'(out_valid), 128'(1));
         out_ready = 1'b1;
         return;
      end
      lat = n;
      got = unmask32(out_data);
      check("latency", 128'(lat), 128'(WORD_LAT + stall_n));
      check("word", 128'(got), 128'(ref_word(w)));
      held = out_data;
      ok   = 1'b1;
      for (int i = 0; i < bp_n; i++) begin
         @(negedge clk);
         if (!(out_valid && (out_data === held) && !in_ready)) ok = 1'b0;
      end
      if (bp_n > 0) check("backpressure_hold", 128'(ok), 128'(1));
      out_ready = 1'b1;
      @(negedge clk);
      check("after_out_hs", 128'({in_ready, out_valid, busy}), 128'(3'b100));
   endtask

   task automatic reset_in_drain();
      int n;
      bit quiet;
      in_data  = mask32($urandom);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);                 // cycle 1
      in_valid = 1'b0;
      repeat (9) @(negedge clk);      // cycle 10: bytes 2 and 3 still in the S-box
      check("drain_before_rst", 128'({busy, out_valid}), 128'(2'b10));
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_flags", 128'({busy, rnd_ready, out_valid, in_ready, rnd_err}), 128'(0));
      check("rst_mid_sb_i", 128'(sb_i), 128'(0));
      check("rst_mid_out_data", 128'(out_data), 128'(0));
      rst   = 1'b0;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || busy) quiet = 1'b0;
      end
      check("rst_mid_no_stale", 128'(quiet), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          lat, hs, prev_hs;
      logic [31:0] got;
      logic [7:0]  inv;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      // Reset
      repeat (2) @(negedge clk);
      check("in_ready_in_rst", 128'(in_ready), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      check("reset_flags", 128'({out_valid, busy, rnd_ready, rnd_err, in_ready}), 128'(5'b00001));
      check("reset_out_data", 128'(out_data), 128'(0));
      check("reset_sb_i", 128'(sb_i), 128'(0));

      // Known-answer word: bytes 0x00, 0x01, 0x53, 0xFF
      run_word(32'hFF530100, 0, 0, lat, got, hs);
      check("kat_b0", 128'(got[7:0]),   128'(8'h63));
      check("kat_b1", 128'(got[15:8]),  128'(8'h7C));
      check("kat_b2", 128'(got[23:16]), 128'(8'hED));
      check("kat_b3", 128'(got[31:24]), 128'(8'h16));
      check("rnd_err_kat", 128'(rnd_err), 128'(0));

      // Randomness missing only while idle is harmless
      rnd_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rnd_err_idle", 128'(rnd_err), 128'(0));
      run_word($urandom, 0, 0, lat, got, hs);
      check("rnd_err_idle_word", 128'(rnd_err), 128'(0));

      // Back-to-back random words
      prev_hs = 0;
      for (int i = 0; i < 100; i++) begin
         run_word($urandom, 0, 0, lat, got, hs);
         if (i > 0) check("word_period", 128'(hs - prev_hs), 128'(WORD_PERIOD));
         prev_hs = hs;
      end
      check("rnd_err_random", 128'(rnd_err), 128'(0));

      // Output backpressure
      run_word($urandom, 0, 10, lat, got, hs);

      // Randomness stall while k=1
      run_word($urandom, 2, 0, lat, got, hs);
      check("rnd_err_stall", 128'(rnd_err), 128'(1));

      // Reset with bytes in flight, then a clean word
      reset_in_drain();
      run_word($urandom, 0, 0, lat, got, hs);
      check("rnd_err_after_rst", 128'(rnd_err), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
